// File: rtl/alu_arbiter_pkg.sv
// Shared global operation encoding and command type for the ALU arbiter slice.
// Every 3-bit code is a legal operation.
package alu_arbiter_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_INC  = 3'd2;
  localparam logic [2:0] OP_DEC  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } alu_cmd_t;

  function automatic logic zero_flag(input logic [7:0] val);
    return (val == 8'h00);
  endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational 8-bit ALU. Its carry output is NOT-borrow for sub/dec and 0 for logic ops.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
(
  input  logic [2:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  output logic [7:0] res_o,
  output logic       c_o,
  output logic       z_o
);

  logic [8:0] wide_s;

  // Operation decode; arithmetic ops are evaluated 9 bits wide to expose the carry
  always_comb begin
    wide_s = 9'd0;
    res_o  = 8'h00;
    c_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        wide_s = {1'b0, a_i} + {1'b0, b_i};
        res_o  = wide_s[7:0];
        c_o    = wide_s[8];
      end
      OP_SUB: begin
        wide_s = {1'b0, a_i} - {1'b0, b_i};
        res_o  = wide_s[7:0];
        c_o    = ~wide_s[8];
      end
      OP_INC: begin
        wide_s = {1'b0, a_i} + 9'd1;
        res_o  = wide_s[7:0];
        c_o    = wide_s[8];
      end
      OP_DEC: begin
        wide_s = {1'b0, a_i} - 9'd1;
        res_o  = wide_s[7:0];
        c_o    = ~wide_s[8];
      end
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_XNOR: res_o = ~(a_i ^ b_i);
      default: res_o = 8'h00;
    endcase
    z_o = zero_flag(res_o);
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared ALU (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); the default is round-robin.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int N_REQ = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0,
  input  logic       req1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic       gnt0,
  output logic       gnt1,
  output logic       rsp_valid0,
  output logic       rsp_valid1,
  output logic [7:0] result,
  output logic       flag_c,
  output logic       flag_z,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]       state_q, state_d;
  alu_cmd_t         cmd_q, cmd_d;
  logic             who_q, who_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] rsp_q, rsp_d;
  logic [7:0]       result_q, result_d;
  logic             c_q, c_d, z_q, z_d;
  logic             win_s;
  logic [7:0]       alu_res_s;
  logic             alu_c_s, alu_z_s;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign win_s = ~req0;
`else
  // last_q == 1 means requester 1 was served last, so requester 0 is favoured
  logic last_q;

  assign win_s = req1 & (~req0 | ~last_q);

  // Round-robin pointer, moved only when a grant is issued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if ((state_q == S_IDLE) && (req0 || req1)) begin
      last_q <= win_s;
    end else begin
      last_q <= last_q;
    end
  end
`endif

  alu_arbiter_alu u_alu (
    .op_i  (cmd_q.op),
    .a_i   (cmd_q.a),
    .b_i   (cmd_q.b),
    .res_o (alu_res_s),
    .c_o   (alu_c_s),
    .z_o   (alu_z_s)
  );

  // Next-state logic: gnt/rsp pulses default low and are set for one cycle only
  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    who_d    = who_q;
    gnt_d    = '0;
    rsp_d    = '0;
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    case (state_q)
      S_IDLE: begin
        if (req0 || req1) begin
          who_d   = win_s;
          cmd_d   = win_s ? '{op: op1, a: a1, b: b1} : '{op: op0, a: a0, b: b0};
          gnt_d   = win_s ? 2'b10 : 2'b01;
          state_d = S_EXEC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXEC: begin
        result_d = alu_res_s;
        c_d      = alu_c_s;
        z_d      = alu_z_s;
        rsp_d    = who_q ? 2'b10 : 2'b01;
        state_d  = S_RESP;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any in-flight operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= '0;
      who_q    <= 1'b0;
      gnt_q    <= '0;
      rsp_q    <= '0;
      result_q <= 8'h00;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      who_q    <= who_d;
      gnt_q    <= gnt_d;
      rsp_q    <= rsp_d;
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
    end
  end

  assign gnt0       = gnt_q[0];
  assign gnt1       = gnt_q[1];
  assign rsp_valid0 = rsp_q[0];
  assign rsp_valid1 = rsp_q[1];
  assign result     = result_q;
  assign flag_c     = c_q;
  assign flag_z     = z_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter; honours ALU_ARB_FIXED_PRIO_EN when defined.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       gnt0, gnt1, rsp_valid0, rsp_valid1;
  logic [7:0] result;
  logic       flag_c, flag_z, busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.N_REQ(2)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1),
    .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .result(result), .flag_c(flag_c), .flag_z(flag_z), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One isolated operation with exact latency checks on gnt and rsp_valid
  task automatic run_single(input string tag, input int who, input logic [2:0] op,
                            input logic [7:0] a, input logic [7:0] b,
                            input logic [7:0] er, input logic ec, input logic ez);
    logic [31:0] code;
    code = (who == 0) ? 32'd1 : 32'd2;
    @(posedge clk); #1;
    if (who == 0) begin
      req0 = 1'b1; op0 = op; a0 = a; b0 = b;
    end else begin
      req1 = 1'b1; op1 = op; a1 = a; b1 = b;
    end
    @(posedge clk); #1;
    check_eq({tag, "_gnt"}, 32'({gnt1, gnt0}), code);
    check_eq({tag, "_busy"}, 32'(busy), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_rsp"}, 32'({rsp_valid1, rsp_valid0}), code);
    check_eq({tag, "_gnt_off"}, 32'({gnt1, gnt0}), 32'd0);
    check_eq({tag, "_res"}, 32'(result), 32'(er));
    check_eq({tag, "_c"}, 32'(flag_c), 32'(ec));
    check_eq({tag, "_z"}, 32'(flag_z), 32'(ez));
    @(posedge clk); #1;
    check_eq({tag, "_rsp_off"}, 32'({rsp_valid1, rsp_valid0}), 32'd0);
    check_eq({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // Wait (bounded) for a grant while both requesters contend, then check its response
  task automatic contend_step(input string tag, input int exp_who);
    logic seen;
    int   who;
    seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      if (gnt0 || gnt1) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq({tag, "_seen"}, 32'(seen), 32'd1);
    check_eq({tag, "_excl"}, 32'(gnt0 & gnt1), 32'd0);
    who = gnt1 ? 1 : 0;
    check_eq({tag, "_who"}, 32'(who), 32'(exp_who));
    @(posedge clk); #1;
    check_eq({tag, "_rsp"}, 32'({rsp_valid1, rsp_valid0}), (exp_who == 0) ? 32'd1 : 32'd2);
    check_eq({tag, "_res"}, 32'(result), (exp_who == 0) ? 32'h03 : 32'hFF);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op0 = 3'd0; op1 = 3'd0; a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    #12;
    check_eq("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check_eq("rst_rsp", 32'({rsp_valid1, rsp_valid0}), 32'd0);
    check_eq("rst_res", 32'(result), 32'd0);
    check_eq("rst_flags", 32'({flag_c, flag_z}), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    run_single("add_f0_20", 0, OP_ADD, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
    run_single("sub_05_05", 1, OP_SUB, 8'h05, 8'h05, 8'h00, 1'b1, 1'b1);
    run_single("sub_03_05", 1, OP_SUB, 8'h03, 8'h05, 8'hFE, 1'b0, 1'b0);
    run_single("inc_ff", 0, OP_INC, 8'hFF, 8'h00, 8'h00, 1'b1, 1'b1);
    run_single("xnor_aa_55", 0, OP_XNOR, 8'hAA, 8'h55, 8'h00, 1'b0, 1'b1);
    run_single("dec_00", 1, OP_DEC, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0);
    run_single("and_f0_3c", 0, OP_AND, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0);
    run_single("or_0f_30", 1, OP_OR, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0);
    run_single("add_80_7f", 1, OP_ADD, 8'h80, 8'h7F, 8'hFF, 1'b0, 1'b0);

    // Contention starts from a fresh reset so the pointer favours requester 0
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    op0 = OP_ADD; a0 = 8'h01; b0 = 8'h02;
    op1 = OP_XOR; a1 = 8'hF0; b1 = 8'h0F;
    req0 = 1'b1; req1 = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 3; i++) contend_step($sformatf("prio%0d", i), 0);
    req0 = 1'b0;
    contend_step("prio_r1", 1);
`else
    for (int i = 0; i < 4; i++) contend_step($sformatf("rr%0d", i), i % 2);
`endif
    req0 = 1'b0; req1 = 1'b0;

    // Reset while the operation sits in EXEC
    @(posedge clk); #1;
    req0 = 1'b1; op0 = OP_ADD; a0 = 8'h01; b0 = 8'h01;
    @(posedge clk); #1;
    check_eq("abort_gnt", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_eq("abort_busy", 32'(busy), 32'd0);
    check_eq("abort_gnt_off", 32'({gnt1, gnt0}), 32'd0);
    check_eq("abort_res", 32'(result), 32'd0);
    check_eq("abort_flags", 32'({flag_c, flag_z}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check_eq("abort_no_rsp", 32'({rsp_valid1, rsp_valid0}), 32'd0);
    end
    run_single("post_rst_add", 0, OP_ADD, 8'h02, 8'h03, 8'h05, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter N_REQ, default 2, number of requesters; only 2 supported.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0 / req1  input  1 each  requester wants one ALU operation.
REQ-005 op0 / op1  input  3 each  operation code, shared global operation encoding.
REQ-006 a0, b0 / a1, b1  input  8 each  operands per requester.
REQ-007 gnt0 / gnt1  output  1 each  one-cycle pulse: request accepted, operands latched.
REQ-008 rsp_valid0 / rsp_valid1  output  1 each  one-cycle pulse: result/flags valid for that requester.
REQ-009 result  output  8  registered ALU result of the last completed operation.
REQ-010 flag_c / flag_z  output  1 each  registered carry (NOT borrow for sub/dec) and zero flags of last completed operation.
REQ-011 busy  output  1  high in any state other than IDLE.

Function
REQ-012 FSM states: IDLE, EXEC, RESP; encoding free.
REQ-013 IDLE: if any req high, latch winner's op/A/B into internal operand registers, set gnt of winner next cycle, go EXEC; else stay IDLE.
REQ-014 EXEC: ALU evaluates latched operands combinationally; result, flag_c, flag_z registered at end of cycle; go RESP.
REQ-015 RESP: rsp_valid of granted requester high for exactly this cycle; return to IDLE.
REQ-016 Latency: req sampled high at edge N -> gnt high cycle N+1 -> rsp_valid high cycle N+2 (result/flags stable from N+2 until next completion).
REQ-017 Throughput: at most one operation per 3 cycles; requests ignored in EXEC and RESP.
REQ-018 Requester holds req and operands stable until its gnt; requester deasserts req in the gnt cycle or it is re-arbitrated as a new request.
REQ-019 Arbitration (default): round-robin; on both req high, grant the requester not granted last; last-granted pointer updates only on grant.
REQ-020 Single req high: granted regardless of pointer.
REQ-021 gnt0 and gnt1 never high together; rsp_valid0 and rsp_valid1 never high together.
REQ-022 Arithmetic: add/inc carry = bit 8 of 9-bit sum; sub/dec carry = inverted bit 8 of 9-bit difference; logic ops carry = 0; zero = result equals 0 for all ops.
REQ-023 Wrap: 8'hFF inc -> 8'h00, C=1, Z=1; 8'h00 dec -> 8'hFF, C=0, Z=0.
REQ-024 Unlisted/illegal op code cannot occur (3-bit fully decoded).

Reset
REQ-025 On rst: state IDLE, gnt*=0, rsp_valid*=0, result=8'h00, flag_c=0, flag_z=0, busy=0, operand regs 0, pointer favours requester 0 first.
REQ-026 Reset mid-operation aborts in-flight op; no rsp_valid issued for it; requester re-requests after reset.

Configuration
REQ-027 Macro ALU_ARB_FIXED_PRIO_EN: defined -> fixed priority, req0 always wins over req1, pointer logic removed.
REQ-028 Undefined -> round-robin per REQ-019; all other behaviour identical.

Structure
REQ-029 Operation codes (addition, subtraction, increment, decrement, bitwise_and/or/xor/xnor) come from the shared global parameter header; no local redefinition.
REQ-030 FSM state constants local to this module.
REQ-031 One sub-module: the existing ALU block, instantiated once, fed from latched operand registers.

Verification
REQ-032 Single req0: op=add, A=8'hF0, B=8'h20 -> gnt0 at N+1, rsp_valid0 at N+2, result=8'h10, C=1, Z=0.
REQ-033 Both req held high, 4 ops back-to-back (round-robin build) -> grant order 0,1,0,1; no overlapping gnt/rsp_valid.
REQ-034 req1 op=sub, A=8'h05, B=8'h05 -> result=8'h00, C=1, Z=1; then A=8'h03, B=8'h05 -> 8'hFE, C=0, Z=0.
REQ-035 req0 op=inc A=8'hFF -> 8'h00, C=1, Z=1; op=xnor A=8'hAA, B=8'h55 -> 8'h00, C=0, Z=1.
REQ-036 Assert rst during EXEC -> no rsp_valid, all outputs zero, busy=0, next req0 completes normally.
REQ-037 With ALU_ARB_FIXED_PRIO_EN, both req held 3 ops -> req0 granted every time, req1 only after req0 drops.
